i2s_sample_tx: RTL

Audio output end of the sample path. Consumes the 16-bit mono `sample` and `play` produced by the music player and serialises each sample as a standard I2S stereo frame (same sample on left and right). It generates the per-frame `new_frame` request that the player synchronises and uses as its sampling pulse. It owns bit-clock and word-clock generation toward the DAC.

---
 rtl/i2s_sample_tx_pkg.sv | 21 ++
 rtl/i2s_sample_tx_bclk_gen.sv | 34 +++
 rtl/i2s_sample_tx.sv | 74 +++++++
 3 files changed

// File: rtl/i2s_sample_tx_pkg.sv
// Shared constants for the I2S sample transmitter: sample width, frame length
// and the slot positions that define the channel and word-select boundaries.
package i2s_sample_tx_pkg;

  localparam int SAMPLE_W    = 16;
  localparam int FRAME_SLOTS = 2 * SAMPLE_W;
  localparam int SLOT_W      = $clog2(FRAME_SLOTS);

  localparam int LEFT_MSB   = 0;
  localparam int LRCLK_RISE = 15;
  localparam int RIGHT_MSB  = 16;
  localparam int LRCLK_FALL = 31;

  typedef logic [SLOT_W-1:0] slot_t;

  // Word select leads each channel MSB by one slot: high for slots 15..30.
  function automatic logic lrclk_for_slot(input slot_t s);
    return (s >= slot_t'(LRCLK_RISE)) && (s < slot_t'(LRCLK_FALL));
  endfunction

endpackage

// File: rtl/i2s_sample_tx_bclk_gen.sv
// Bit-clock divider: bclk toggles every CLK_DIV clk cycles; the strobes are high
// during the cycle whose closing clk edge produces the matching bclk transition.
module i2s_sample_tx_bclk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic bclk,
  output logic rise_evt,
  output logic fall_evt
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] div;
  logic             tc;

  assign tc       = (div == DIV_W'(CLK_DIV - 1));
  assign rise_evt = tc & ~bclk;
  assign fall_evt = tc & bclk;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div  <= '0;
      bclk <= 1'b0;
    end else if (tc) begin
      div  <= '0;
      bclk <= ~bclk;
    end else begin
      div  <= div + 1'b1;
    end
  end

endmodule

// File: rtl/i2s_sample_tx.sv
// I2S stereo transmitter: latches one mono sample per frame, sends it on both
// channels MSB first, and requests the next sample with a one-clk new_frame pulse.
module i2s_sample_tx #(
  parameter int CLK_DIV  = 4,
  parameter int SAMPLE_W = i2s_sample_tx_pkg::SAMPLE_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic signed [SAMPLE_W-1:0] sample,
  input  logic                       play,
  output logic                       new_frame,
  output logic                       bclk,
  output logic                       lrclk,
  output logic                       sdata
);

  import i2s_sample_tx_pkg::*;

  logic                       fall_evt;
  logic                       rise_unused;
  slot_t                      slot;
  slot_t                      next_slot;
  logic                       load_strobe;
  logic                       load_p1;
  logic signed [SAMPLE_W-1:0] frame_word;
  logic signed [SAMPLE_W-1:0] shift_reg;
  logic signed [SAMPLE_W-1:0] hold_reg;

  i2s_sample_tx_bclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) bclk_gen (
    .clk      (clk),
    .reset    (reset),
    .bclk     (bclk),
    .rise_evt (rise_unused),
    .fall_evt (fall_evt)
  );

  assign next_slot   = slot + 1'b1;
  assign load_strobe = fall_evt && (next_slot == slot_t'(LEFT_MSB));
  assign frame_word  = play ? sample : '0;

  // Everything DAC-facing moves on bclk falls; new_frame trails the load by one clk.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot      <= slot_t'(LRCLK_FALL);
      shift_reg <= '0;
      hold_reg  <= '0;
      sdata     <= 1'b0;
      lrclk     <= 1'b0;
      load_p1   <= 1'b0;
      new_frame <= 1'b0;
    end else begin
      load_p1   <= load_strobe;
      new_frame <= load_p1;
      if (fall_evt) begin
        slot  <= next_slot;
        lrclk <= lrclk_for_slot(next_slot);
        if (next_slot == slot_t'(LEFT_MSB)) begin
          hold_reg  <= frame_word;
          shift_reg <= frame_word;
          sdata     <= frame_word[SAMPLE_W-1];
        end else if (next_slot == slot_t'(RIGHT_MSB)) begin
          shift_reg <= hold_reg;
          sdata     <= hold_reg[SAMPLE_W-1];
        end else begin
          shift_reg <= {shift_reg[SAMPLE_W-2:0], 1'b0};
          sdata     <= shift_reg[SAMPLE_W-2];
        end
      end
    end
  end

endmodule
